// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port, word-addressed data memory.
// Round-robin grant selection, out-of-range checking, and read data returned to the requester that issued the read.
module dmem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int BURST_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_write_enable,
  output logic          mem_read_enable,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic { OWN_A, OWN_B } owner_t;
  typedef enum logic [1:0] { PEND_NONE, PEND_A, PEND_B } pend_t;

  owner_t        last_owner;
  pend_t         pend_owner;
  logic [3:0]    burst_cnt;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic          granted, sel_we, in_range, other_req, same_owner;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // When both ports request, the port that did not own the last grant wins.
  // The burst limit also selects that port, so both rules give the same result.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && !b_req) begin
      a_gnt = 1'b1;
    end else if (b_req && !a_req) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      a_gnt = (last_owner == OWN_B);
      b_gnt = (last_owner == OWN_A);
    end
  end

  always_comb begin
    granted          = a_gnt || b_gnt;
    sel_we           = b_gnt ? b_we    : a_we;
    sel_addr         = b_gnt ? b_addr  : a_addr;
    sel_wdata        = b_gnt ? b_wdata : a_wdata;
    in_range         = (sel_addr < AW'(DEPTH));
    other_req        = a_gnt ? b_req : a_req;
    same_owner       = (a_gnt && last_owner == OWN_A) || (b_gnt && last_owner == OWN_B);
    mem_write_enable = granted && in_range && sel_we;
    mem_read_enable  = granted && in_range && !sel_we;
    mem_address      = (granted && in_range) ? sel_addr  : '0;
    mem_data_in      = (granted && in_range) ? sel_wdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_B;
      burst_cnt  <= 4'd0;
    end else if (granted) begin
      last_owner <= a_gnt ? OWN_A : OWN_B;
      if (same_owner && other_req)
        burst_cnt <= (burst_cnt >= 4'(BURST_LIMIT)) ? 4'(BURST_LIMIT) : burst_cnt + 4'd1;
      else
        burst_cnt <= 4'd1;
    end
  end

  // Out-of-range reads still return a response, flagged by err and carrying zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      pend_owner <= PEND_NONE;
    end else begin
      a_rvalid   <= a_gnt && !a_we;
      b_rvalid   <= b_gnt && !b_we;
      a_err      <= a_gnt && !in_range;
      b_err      <= b_gnt && !in_range;
      pend_owner <= mem_read_enable ? (a_gnt ? PEND_A : PEND_B) : PEND_NONE;
    end
  end

  always_comb begin
    a_rdata = a_rdata_q;
    b_rdata = b_rdata_q;
    if (a_rvalid)
      a_rdata = (pend_owner == PEND_A) ? mem_data_out : '0;
    if (b_rvalid)
      b_rdata = (pend_owner == PEND_B) ? mem_data_out : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid)
        a_rdata_q <= a_rdata;
      if (b_rvalid)
        b_rdata_q <= b_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reference arbitration model plus a response scoreboard.
// A behavioural memory with one-cycle read latency sits on the memory side of the DUT.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_enable, mem_read_enable;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out)
  );

  // Memory seen by the DUT; reads return data on the cycle after the enable.
  logic [31:0] env_mem [0:1023];
  always @(posedge clk) begin
    if (mem_write_enable) env_mem[mem_address[9:0]] <= mem_data_in;
    if (mem_read_enable)  mem_data_out <= env_mem[mem_address[9:0]];
  end

  typedef struct {
    int          due;
    logic        port;
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ref_mem [0:1023];
  logic        last_own;
  logic [31:0] exp_a_rdata, exp_b_rdata;
  int          cycle = 0;
  int          starve_b = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares grants, memory strobes and due responses against the reference, then advances the model.
  task automatic checkOutput();
    logic        ea, eb, g, port, we, in_rng;
    logic [31:0] addr, wdata;
    resp_t       r;
    ea = a_req && (!b_req || last_own);
    eb = b_req && (!a_req || !last_own);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    g      = ea || eb;
    port   = eb;
    we     = eb ? b_we : a_we;
    addr   = eb ? b_addr : a_addr;
    wdata  = eb ? b_wdata : a_wdata;
    in_rng = addr < 32'd1024;
    chk("mem_write_enable", mem_write_enable, g && in_rng && we);
    chk("mem_read_enable", mem_read_enable, g && in_rng && !we);
    if (g && in_rng) chk("mem_address", mem_address, addr);
    if (g && in_rng && we) chk("mem_data_in", mem_data_in, wdata);

    r = '{due: 0, port: 1'b0, valid: 1'b0, err: 1'b0, data: 32'h0};
    if (sb.size() > 0 && sb[0].due == cycle) r = sb.pop_front();
    chk("a_rvalid", a_rvalid, r.valid && !r.port);
    chk("b_rvalid", b_rvalid, r.valid && r.port);
    chk("a_err", a_err, r.err && !r.port);
    chk("b_err", b_err, r.err && r.port);
    if (r.valid && !r.port) exp_a_rdata = r.data;
    if (r.valid && r.port)  exp_b_rdata = r.data;
    chk("a_rdata", a_rdata, exp_a_rdata);
    chk("b_rdata", b_rdata, exp_b_rdata);

    if (b_req && !b_gnt) starve_b++; else starve_b = 0;
    chk("b_starve_le2", 32'(starve_b <= 2), 32'd1);

    if (g) begin
      last_own = port;
      if (!in_rng)
        sb.push_back('{due: cycle + 1, port: port, valid: !we, err: 1'b1, data: 32'h0});
      else if (!we)
        sb.push_back('{due: cycle + 1, port: port, valid: 1'b1, err: 1'b0, data: ref_mem[addr[9:0]]});
      else
        ref_mem[addr[9:0]] = wdata;
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                               input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    checkOutput();
    @(posedge clk); #1;
    cycle++;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    reset = 1'b1;
    sb.delete();
    exp_a_rdata = '0; exp_b_rdata = '0;
    last_own = 1'b1;
    starve_b = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_en", {mem_write_enable, mem_read_enable}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle += 2;
  endtask

  initial begin
    doReset();

    // Single-port write then read-back
    applyStimulus(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    idle();

    // Preload locations used below, from both ports
    applyStimulus(1, 1, 1, 32'h1111_1111, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 32'h2222_2222);
    applyStimulus(1, 1, 10, 32'hA0A0_0010, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 11, 32'hB0B0_0011);
    applyStimulus(1, 1, 0, 32'h0000_1234, 0, 0, 0, 0);

    // Contention from reset: A wins first, then strict alternation
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
    idle();

    // Back-to-back reads from alternate ports
    applyStimulus(1, 0, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 11, 0);
    idle();

    // B held while A re-requests every cycle, mixing writes and reads
    for (int i = 0; i < 6; i++) applyStimulus(1, i[0], 3, 32'h3300_0000 + i, 1, 0, 2, 0);
    idle();

    // Out-of-range accesses
    applyStimulus(1, 0, 1024, 0, 0, 0, 0, 0);
    idle();
    applyStimulus(1, 1, 1024, 32'h0BAD_0BAD, 0, 0, 0, 0);
    applyStimulus(1, 1, 2000, 32'h0BAD_F00D, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 5000, 0);
    idle();

    // Reset lands on the cycle a B read response would appear
    applyStimulus(0, 0, 0, 0, 1, 0, 2, 0);
    reset = 1'b1;
    b_req = 0;
    sb.delete();
    exp_a_rdata = '0; exp_b_rdata = '0;
    last_own = 1'b1;
    starve_b = 0;
    @(negedge clk);
    chk("midrst_b_rvalid", b_rvalid, 0);
    chk("midrst_b_rdata", b_rdata, 0);
    chk("midrst_a_rdata", a_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle++;
    applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
